// File: rtl/decoder_pkg.sv
// Shared types and helpers for the registered one-hot decoder.
package decoder_pkg;

    typedef enum logic {
        DIRECT = 1'b0,
        SCAN   = 1'b1
    } state_e;

    // Widest one-hot the helper can build; callers size-cast down to OUT_W (IN_W <= 6).
    localparam int ONEHOT_MAX_W = 64;

    function automatic logic [ONEHOT_MAX_W-1:0] onehot(input int unsigned code);
        return ONEHOT_MAX_W'(1) << code;
    endfunction

endpackage

// File: rtl/decoder_scan_ctr.sv
// Dwell counter plus wrapping code counter used by the auto-scan mode.
module decoder_scan_ctr #(
    parameter int IN_W  = 2,
    parameter int DWELL = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            run,
    output logic [IN_W-1:0] scan_code,
    output logic            step
);

    localparam int            CW   = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    logic [CW-1:0] dwell_q;

    // step marks the cycle in which the code advances to the next line.
    assign step = run & (dwell_q == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell_q   <= '0;
            scan_code <= '0;
        end else if (start) begin
            dwell_q   <= '0;
            scan_code <= '0;
        end else if (run) begin
            if (step) begin
                dwell_q   <= '0;
                scan_code <= scan_code + IN_W'(1);
            end else begin
                dwell_q <= dwell_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/decoder_onehot_seq.sv
// Registered binary-to-one-hot decoder with handshake, output enable and
// optional auto-scan mode (compiled in when DECODER_SCAN_EN is defined).
module decoder_onehot_seq
    import decoder_pkg::*;
#(
    parameter  int IN_W  = 2,
    parameter  int DWELL = 4,
    localparam int OUT_W = 2 ** IN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             en,
    input  logic             scan_mode,
    output logic [OUT_W-1:0] out,
    output logic             out_valid,
    output logic [IN_W-1:0]  code
);

    // Handshake: a transfer happens on a rising edge where in_valid & in_ready;
    // in_ready is combinational from en/scan_mode and never depends on in_valid.

    logic [OUT_W-1:0] out_q;
    logic             out_valid_q;
    logic [IN_W-1:0]  code_q;
    logic             loaded_q;
    logic             xfer;

    assign xfer      = in_valid & in_ready;
    assign out       = out_q;
    assign out_valid = out_valid_q;

`ifdef DECODER_SCAN_EN
    state_e          state;
    logic            start;
    logic            run;
    logic            step;
    logic [IN_W-1:0] scan_code;
    logic [IN_W-1:0] scan_next;

    assign in_ready  = en & ~scan_mode;
    assign start     = (state == DIRECT) & scan_mode;
    assign run       = (state == SCAN) & scan_mode & en;
    assign scan_next = step ? scan_code + IN_W'(1) : scan_code;
    // While scanning the counter owns the code; on exit code_q captures it.
    assign code      = (state == SCAN) ? scan_code : code_q;

    decoder_scan_ctr #(
        .IN_W  (IN_W),
        .DWELL (DWELL)
    ) u_scan_ctr (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .run       (run),
        .scan_code (scan_code),
        .step      (step)
    );
`else
    localparam int unused_dwell = DWELL;
    logic unused_scan_mode;

    assign unused_scan_mode = scan_mode;
    assign in_ready         = en;
    assign code             = code_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            code_q      <= '0;
            loaded_q    <= 1'b0;
`ifdef DECODER_SCAN_EN
            state       <= DIRECT;
`endif
        end else begin
`ifdef DECODER_SCAN_EN
            if (scan_mode) begin
                state <= SCAN;
                if (state == DIRECT) begin
                    code_q      <= '0;
                    loaded_q    <= 1'b1;
                    out_q       <= en ? OUT_W'(onehot(0)) : '0;
                    out_valid_q <= en;
                end else if (!en) begin
                    out_q       <= '0;
                    out_valid_q <= 1'b0;
                end else begin
                    out_q       <= OUT_W'(onehot(32'(scan_next)));
                    out_valid_q <= 1'b1;
                end
            end else begin
                state <= DIRECT;
`endif
                code_q <= code;
                if (!en) begin
                    out_q       <= '0;
                    out_valid_q <= 1'b0;
                end else if (xfer) begin
                    code_q      <= in;
                    out_q       <= OUT_W'(onehot(32'(in)));
                    out_valid_q <= 1'b1;
                    loaded_q    <= 1'b1;
                end else if (loaded_q) begin
                    out_q       <= OUT_W'(onehot(32'(code)));
                    out_valid_q <= 1'b1;
                end
`ifdef DECODER_SCAN_EN
            end
`endif
        end
    end

endmodule

// File: tb/tb_decoder_onehot_seq.sv
// Directed self-checking bench for decoder_onehot_seq (IN_W=2, DWELL=4);
// scan scenarios run when DECODER_SCAN_EN is defined.
module tb_decoder_onehot_seq;

    localparam int IN_W  = 2;
    localparam int DWELL = 4;
    localparam int OUT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [IN_W-1:0]  in = '0;
    logic             in_valid = 1'b0;
    logic             en = 1'b0;
    logic             scan_mode = 1'b0;
    logic             in_ready;
    logic [OUT_W-1:0] out;
    logic             out_valid;
    logic [IN_W-1:0]  code;

    int checks = 0;
    int errors = 0;

    decoder_onehot_seq #(
        .IN_W  (IN_W),
        .DWELL (DWELL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .en        (en),
        .scan_mode (scan_mode),
        .out       (out),
        .out_valid (out_valid),
        .code      (code)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (out !== 4'b0000) begin errors++; $display("FAIL reset_out got %b exp 0000", out); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
        checks++; if (code !== 2'd0) begin errors++; $display("FAIL reset_code got %0d exp 0", code); end
        tick();
        rst_n = 1'b1; en = 1'b1; scan_mode = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", in_ready); end
        // enable toggle before any load must not produce a valid output
        en = 1'b0; tick();
        en = 1'b1; tick();
        checks++; if (out !== 4'b0000) begin errors++; $display("FAIL unloaded_out got %b exp 0000", out); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL unloaded_valid got %b exp 0", out_valid); end
    endtask

    task automatic test_direct();
        in = 2'b10; in_valid = 1'b1; tick();
        in_valid = 1'b0;
        checks++; if (out !== 4'b0100) begin errors++; $display("FAIL direct_out got %b exp 0100", out); end
        checks++; if (code !== 2'd2) begin errors++; $display("FAIL direct_code got %0d exp 2", code); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL direct_valid got %b exp 1", out_valid); end
        in = 2'b11; tick();
        checks++; if (out !== 4'b0100) begin errors++; $display("FAIL direct_hold got %b exp 0100", out); end
    endtask

    task automatic test_back_to_back();
        logic [IN_W-1:0]  vec_in  [3] = '{2'd0, 2'd1, 2'd3};
        logic [OUT_W-1:0] vec_out [3] = '{4'b0001, 4'b0010, 4'b1000};
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in = vec_in[i]; tick();
            checks++; if (out !== vec_out[i]) begin errors++; $display("FAIL b2b_out[%0d] got %b exp %b", i, out, vec_out[i]); end
            checks++; if (code !== vec_in[i]) begin errors++; $display("FAIL b2b_code[%0d] got %0d exp %0d", i, code, vec_in[i]); end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_enable();
        in = 2'd3; in_valid = 1'b1; tick();
        in_valid = 1'b0; en = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL en_ready got %b exp 0", in_ready); end
        tick();
        checks++; if (out !== 4'b0000) begin errors++; $display("FAIL en_off_out got %b exp 0000", out); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL en_off_valid got %b exp 0", out_valid); end
        checks++; if (code !== 2'd3) begin errors++; $display("FAIL en_off_code got %0d exp 3", code); end
        en = 1'b1; tick();
        checks++; if (out !== 4'b1000) begin errors++; $display("FAIL en_on_out got %b exp 1000", out); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL en_on_valid got %b exp 1", out_valid); end
    endtask

`ifdef DECODER_SCAN_EN
    task automatic test_scan();
        logic [OUT_W-1:0] exp_out;
        logic [IN_W-1:0]  exp_code;
        // in_valid rises together with scan_mode: no transfer, scan starts at 0
        scan_mode = 1'b1; in_valid = 1'b1; in = 2'd3;
        for (int i = 0; i <= 16; i++) begin
            tick();
            exp_code = IN_W'((i / DWELL) % OUT_W);
            exp_out  = OUT_W'(1) << exp_code;
            checks++; if (out !== exp_out) begin errors++; $display("FAIL scan_out[%0d] got %b exp %b", i, out, exp_out); end
            checks++; if (code !== exp_code) begin errors++; $display("FAIL scan_code[%0d] got %0d exp %0d", i, code, exp_code); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL scan_ready[%0d] got %b exp 0", i, in_ready); end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_scan_freeze();
        logic [OUT_W-1:0] exp_out;
        // line 0 dwell 0 -> line 2 dwell 1 takes nine steps
        for (int i = 0; i < 9; i++) tick();
        checks++; if (out !== 4'b0100) begin errors++; $display("FAIL frz_pre got %b exp 0100", out); end
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (out !== 4'b0000) begin errors++; $display("FAIL frz_off[%0d] got %b exp 0000", i, out); end
            checks++; if (code !== 2'd2) begin errors++; $display("FAIL frz_code[%0d] got %0d exp 2", i, code); end
        end
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_out = (i < 2) ? 4'b0100 : 4'b1000;
            checks++; if (out !== exp_out) begin errors++; $display("FAIL frz_resume[%0d] got %b exp %b", i, out, exp_out); end
        end
        scan_mode = 1'b0; tick();
        checks++; if (out !== 4'b1000) begin errors++; $display("FAIL exit_out got %b exp 1000", out); end
        checks++; if (code !== 2'd3) begin errors++; $display("FAIL exit_code got %0d exp 3", code); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL exit_ready got %b exp 1", in_ready); end
        tick();
        checks++; if (out !== 4'b1000) begin errors++; $display("FAIL exit_hold got %b exp 1000", out); end
        in = 2'd1; in_valid = 1'b1; tick();
        in_valid = 1'b0;
        checks++; if (out !== 4'b0010) begin errors++; $display("FAIL exit_xfer got %b exp 0010", out); end
    endtask
`else
    task automatic test_scan_ignored();
        scan_mode = 1'b1; in = 2'd1; in_valid = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL noscan_ready got %b exp 1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (out !== 4'b0010) begin errors++; $display("FAIL noscan_out got %b exp 0010", out); end
        checks++; if (code !== 2'd1) begin errors++; $display("FAIL noscan_code got %0d exp 1", code); end
        tick();
        checks++; if (out !== 4'b0010) begin errors++; $display("FAIL noscan_hold got %b exp 0010", out); end
        scan_mode = 1'b0;
    endtask
`endif

    task automatic test_reset_mid();
        in = 2'd1; in_valid = 1'b1; tick();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if (out !== 4'b0000) begin errors++; $display("FAIL mid_rst_out got %b exp 0000", out); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b exp 0", out_valid); end
        checks++; if (code !== 2'd0) begin errors++; $display("FAIL mid_rst_code got %0d exp 0", code); end
        tick();
        rst_n = 1'b1; tick();
        checks++; if (out !== 4'b0000) begin errors++; $display("FAIL post_rst_out got %b exp 0000", out); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_rst_valid got %b exp 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready got %b exp 1", in_ready); end
    endtask

    initial begin
        test_reset();
        test_direct();
        test_back_to_back();
        test_enable();
`ifdef DECODER_SCAN_EN
        test_scan();
        test_scan_freeze();
`else
        test_scan_ignored();
`endif
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
